// File: rtl/pulse_monitor.sv
// pulse_monitor: receive-side decoder for the sync_on / pulse_on / inhib
// sequence lines. Each frame (sync_on rise to sync_on rise) is measured back
// into period, pump width, delay, first pi width, pi count, block delay and
// first inhib window width. The results are published with a one-cycle
// meas_valid strobe when the next frame starts.
module pulse_monitor #(
   parameter int unsigned   CW      = 32,
   parameter logic [CW-1:0] TIMEOUT = 32'd200_000_000
) (
   input  logic          clk_pll,
   input  logic          reset,
   input  logic          sync_on,
   input  logic          pulse_on,
   input  logic          inhib,
   output logic [CW-1:0] meas_period,
   output logic [CW-1:0] meas_p1width,
   output logic [CW-1:0] meas_delay,
   output logic [CW-1:0] meas_p2width,
   output logic [7:0]    meas_npulses,
   output logic [CW-1:0] meas_block,
   output logic [CW-1:0] meas_window,
   output logic          meas_valid,
   output logic          timeout
);

   typedef enum logic [2:0] {IDLE, P1, GAP, PI, POST} state_t;
   typedef enum logic [1:0] {IB_WAIT, IB_BLK, IB_WIN, IB_DONE} ib_state_t;

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t        state;
   ib_state_t     ib_state;
   logic          s_d, p_d, i_d;
   logic          sync_rise, pulse_rise, pulse_fall, inhib_rise, inhib_fall;
   logic          have_frame;
   logic [CW-1:0] frame_cnt, cnt, ib_cnt;
   logic [CW-1:0] w_p1, w_dly, w_p2, w_blk, w_win;
   logic [7:0]    w_np;
   logic [CW-1:0] fin_p1, fin_dly, fin_p2, fin_blk, fin_win;

   // one-cycle history of the three lines for edge detection
   always_ff @(posedge clk_pll or negedge reset) begin
      if (!reset) begin
         s_d <= 1'b0;
         p_d <= 1'b0;
         i_d <= 1'b0;
      end else begin
         s_d <= sync_on;
         p_d <= pulse_on;
         i_d <= inhib;
      end
   end

   // edge decode and the values a frame reports if closed this cycle
   always_comb begin
      sync_rise  = sync_on & ~s_d;
      pulse_rise = pulse_on & ~p_d;
      pulse_fall = ~pulse_on & p_d;
      inhib_rise = inhib & ~i_d;
      inhib_fall = ~inhib & i_d;
      // a count still running when sync rises is reported at its current value
      fin_p1  = (state == P1)  ? cnt : w_p1;
      fin_dly = (state == GAP) ? cnt : w_dly;
      fin_p2  = (state == PI && w_np == 8'd1) ? cnt : w_p2;
      // block/window only report once the window has actually opened
      fin_blk = '0;
      fin_win = '0;
      if (ib_state == IB_WIN) begin
         fin_blk = w_blk;
         fin_win = ib_cnt;
      end else if (ib_state == IB_DONE) begin
         fin_blk = w_blk;
         fin_win = w_win;
      end
   end

   // frame sequencing, pulse/inhib measurement and result publication
   always_ff @(posedge clk_pll or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ib_state     <= IB_WAIT;
         have_frame   <= 1'b0;
         frame_cnt    <= '0;
         cnt          <= '0;
         ib_cnt       <= '0;
         w_p1         <= '0;
         w_dly        <= '0;
         w_p2         <= '0;
         w_blk        <= '0;
         w_win        <= '0;
         w_np         <= '0;
         meas_period  <= '0;
         meas_p1width <= '0;
         meas_delay   <= '0;
         meas_p2width <= '0;
         meas_npulses <= '0;
         meas_block   <= '0;
         meas_window  <= '0;
         meas_valid   <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (frame_cnt != '1)
            frame_cnt <= frame_cnt + ONE;

         if (sync_rise) begin
            // close the running frame, then open the new one in the same cycle
            if (have_frame) begin
               meas_period  <= frame_cnt;
               meas_p1width <= fin_p1;
               meas_delay   <= fin_dly;
               meas_p2width <= fin_p2;
               meas_npulses <= w_np;
               meas_block   <= fin_blk;
               meas_window  <= fin_win;
               meas_valid   <= 1'b1;
            end
            have_frame <= 1'b1;
            timeout    <= 1'b0;
            frame_cnt  <= ONE;
            cnt        <= ONE;
            ib_cnt     <= '0;
            ib_state   <= IB_WAIT;
            w_p1       <= '0;
            w_dly      <= '0;
            w_p2       <= '0;
            w_blk      <= '0;
            w_win      <= '0;
            w_np       <= '0;
            state      <= pulse_on ? P1 : GAP;
         end else if (frame_cnt == TIMEOUT) begin
            timeout    <= 1'b1;
            have_frame <= 1'b0;
            state      <= IDLE;
            ib_state   <= IB_WAIT;
         end else begin
            case (state)
               P1: begin
                  if (pulse_fall) begin
                     w_p1  <= cnt;
                     cnt   <= ONE;
                     state <= GAP;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
               GAP: begin
                  if (pulse_rise) begin
                     w_dly <= cnt;
                     w_np  <= 8'd1;
                     cnt   <= ONE;
                     state <= PI;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
               PI: begin
                  if (pulse_fall) begin
                     if (w_np == 8'd1)
                        w_p2 <= cnt;
                     state <= POST;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
               POST: begin
                  if (pulse_rise) begin
                     if (w_np != 8'hFF)
                        w_np <= w_np + 8'd1;
                     cnt   <= ONE;
                     state <= PI;
                  end
               end
               default: ;
            endcase

            case (ib_state)
               IB_WAIT: begin
                  if (state == PI && pulse_fall) begin
                     ib_cnt <= ONE;
                     if (!inhib) begin
                        w_blk    <= '0;
                        ib_state <= IB_WIN;
                     end else begin
                        ib_state <= IB_BLK;
                     end
                  end
               end
               IB_BLK: begin
                  if (inhib_fall) begin
                     w_blk    <= ib_cnt;
                     ib_cnt   <= ONE;
                     ib_state <= IB_WIN;
                  end else begin
                     ib_cnt <= ib_cnt + ONE;
                  end
               end
               IB_WIN: begin
                  if (inhib_rise) begin
                     w_win    <= ib_cnt;
                     ib_state <= IB_DONE;
                  end else begin
                     ib_cnt <= ib_cnt + ONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: drives synthetic sequence frames into pulse_monitor and
// scores every meas_valid strobe against the timing of the frame it closes.
`timescale 1ns/1ps
module tb_pulse_monitor;

   typedef struct {
      int period;
      bit pump;
      int p1w;
      int pist;   // cycle of the first pi rise, relative to the sync rise
      int p2w;
      int npi;
      int pisp;   // pi rise-to-rise spacing
      int blk;
      int win;
   } frame_t;

   typedef struct {
      int unsigned period, p1, dly, p2, np, blk, win;
   } exp_t;

   logic        clk_pll, reset, sync_on, pulse_on, inhib;
   logic [31:0] meas_period, meas_p1width, meas_delay, meas_p2width;
   logic [31:0] meas_block, meas_window;
   logic [7:0]  meas_npulses;
   logic        meas_valid, timeout;

   int   n_pass = 0;
   int   n_total = 0;
   int   n_frames = 0;
   exp_t sb[$];

   exp_t        mon_e;
   logic [31:0] mon_got[7];
   logic [31:0] mon_req[7];
   string       fname[7] = '{"period", "p1width", "delay", "p2width", "npulses", "block", "window"};

   frame_t HAHN  = '{period:1000, pump:1'b1, p1w:20, pist:100, p2w:40, npi:1,   pisp:1000, blk:10, win:200};
   frame_t CPMG  = '{period:1000, pump:1'b1, p1w:20, pist:100, p2w:40, npi:4,   pisp:200,  blk:10, win:200};
   frame_t PUMP0 = '{period:1000, pump:1'b0, p1w:20, pist:120, p2w:40, npi:1,   pisp:1000, blk:10, win:200};
   frame_t TRUNC = '{period:115,  pump:1'b1, p1w:20, pist:100, p2w:40, npi:1,   pisp:1000, blk:10, win:200};
   frame_t SAT   = '{period:1400, pump:1'b1, p1w:20, pist:100, p2w:2,  npi:300, pisp:4,    blk:10, win:200};

   pulse_monitor #(.CW(32), .TIMEOUT(32'd5000)) dut (
      .clk_pll      (clk_pll),
      .reset        (reset),
      .sync_on      (sync_on),
      .pulse_on     (pulse_on),
      .inhib        (inhib),
      .meas_period  (meas_period),
      .meas_p1width (meas_p1width),
      .meas_delay   (meas_delay),
      .meas_p2width (meas_p2width),
      .meas_npulses (meas_npulses),
      .meas_block   (meas_block),
      .meas_window  (meas_window),
      .meas_valid   (meas_valid),
      .timeout      (timeout)
   );

   initial clk_pll = 1'b0;
   always #5 clk_pll = ~clk_pll;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   // expected measurement of a frame, derived from its line waveform
   function automatic exp_t expect_of(input frame_t f);
      exp_t e;
      int   fall, w0, n;
      e.period = f.period;
      e.p1 = f.pump ? f.p1w : 0;
      e.dly = 0; e.p2 = 0; e.np = 0; e.blk = 0; e.win = 0;
      if (f.pist < f.period) begin
         e.dly = f.pist - (f.pump ? f.p1w : 0);
         e.p2 = (f.p2w < f.period - f.pist) ? f.p2w : f.period - f.pist;
         n = 0;
         for (int k = 0; k < f.npi; k++)
            if (f.pist + k * f.pisp < f.period) n++;
         e.np = (n > 255) ? 255 : n;
      end
      fall = f.pist + f.p2w;
      w0 = fall + f.blk;
      if (f.win > 0 && fall < f.period && w0 < f.period) begin
         e.blk = f.blk;
         e.win = (f.win < f.period - w0) ? f.win : f.period - w0;
      end
      return e;
   endfunction

   task automatic step(input logic s, input logic p, input logic i);
      @(posedge clk_pll);
      #1;
      sync_on = s;
      pulse_on = p;
      inhib = i;
   endtask

   task automatic drive_frame(input frame_t f, input int ncyc, input bit push);
      int   w0;
      logic p;
      w0 = f.pist + f.p2w + f.blk;
      for (int c = 0; c < ncyc; c++) begin
         p = (f.pump && c < f.p1w);
         if (c >= f.pist && (c - f.pist) / f.pisp < f.npi && (c - f.pist) % f.pisp < f.p2w)
            p = 1'b1;
         step(c < 8, p, !(f.win > 0 && c >= w0 && c < w0 + f.win));
      end
      if (push) sb.push_back(expect_of(f));
   endtask

   // scoreboard: each strobe closes the oldest pending frame
   always @(negedge clk_pll) begin
      if (reset && meas_valid) begin
         if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_valid: meas_valid=1 with no frame pending, required 0 (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            n_frames++;
            mon_got = '{meas_period, meas_p1width, meas_delay, meas_p2width,
                        {24'd0, meas_npulses}, meas_block, meas_window};
            mon_req = '{mon_e.period, mon_e.p1, mon_e.dly, mon_e.p2, mon_e.np, mon_e.blk, mon_e.win};
            for (int k = 0; k < 7; k++) begin
               n_total++;
               if (mon_got[k] !== mon_req[k])
                  $display("FAIL frame%0d_%s: got %0d required %0d", n_frames, fname[k], mon_got[k], mon_req[k]);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic test_reset();
      logic [31:0] got[11];
      string       nm[11] = '{"rst_period", "rst_p1width", "rst_delay", "rst_p2width", "rst_npulses",
                              "rst_block", "rst_window", "rst_valid", "rst_timeout", "rst_pad0", "rst_pad1"};
      reset = 1'b0; sync_on = 1'b0; pulse_on = 1'b0; inhib = 1'b1;
      repeat (4) @(posedge clk_pll);
      #1;
      got = '{meas_period, meas_p1width, meas_delay, meas_p2width, {24'd0, meas_npulses},
              meas_block, meas_window, {31'd0, meas_valid}, {31'd0, timeout}, 32'd0, 32'd0};
      for (int k = 0; k < 9; k++) begin
         n_total++;
         if (got[k] !== 32'd0) $display("FAIL %s: got %0d required 0", nm[k], got[k]);
         else n_pass++;
      end
      @(posedge clk_pll);
      #1 reset = 1'b1;
      repeat (5) step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic check_pending(input string nm, input int req);
      n_total++;
      if (sb.size() != req) $display("FAIL %s_pending: got %0d required %0d", nm, sb.size(), req);
      else n_pass++;
   endtask

   task automatic test_hahn();
      repeat (3) drive_frame(HAHN, HAHN.period, 1'b1);
      check_pending("hahn", 1);
   endtask

   task automatic test_cpmg();
      repeat (2) drive_frame(CPMG, CPMG.period, 1'b1);
      check_pending("cpmg", 1);
   endtask

   task automatic test_pump_off();
      repeat (2) drive_frame(PUMP0, PUMP0.period, 1'b1);
      check_pending("pump_off", 1);
   endtask

   task automatic test_truncation();
      drive_frame(TRUNC, TRUNC.period, 1'b1);
      drive_frame(HAHN, HAHN.period, 1'b1);
      check_pending("trunc", 1);
   endtask

   task automatic test_saturation();
      drive_frame(SAT, SAT.period, 1'b1);
      check_pending("sat", 1);
   endtask

   task automatic test_timeout();
      for (int i = 0; i <= 5010; i++) begin
         step(1'b1, 1'b1, 1'b1);
         if (i == 5000) begin
            n_total++;
            if (timeout !== 1'b0) $display("FAIL timeout_early: got %0b required 0", timeout);
            else n_pass++;
         end
         if (i == 5001) begin
            n_total++;
            if (timeout !== 1'b1) $display("FAIL timeout_set: got %0b required 1", timeout);
            else n_pass++;
         end
      end
      check_pending("timeout_hold", 0);
      n_total++;
      if (meas_period !== 32'd1400) $display("FAIL timeout_hold_period: got %0d required 1400", meas_period);
      else n_pass++;
      n_total++;
      if (meas_npulses !== 8'd255) $display("FAIL timeout_hold_npulses: got %0d required 255", meas_npulses);
      else n_pass++;
      repeat (20) step(1'b0, 1'b0, 1'b1);
      n_total++;
      if (timeout !== 1'b1) $display("FAIL timeout_sticky: got %0b required 1", timeout);
      else n_pass++;
      drive_frame(HAHN, HAHN.period, 1'b1);
      n_total++;
      if (timeout !== 1'b0) $display("FAIL timeout_clear: got %0b required 0", timeout);
      else n_pass++;
      check_pending("timeout_after", 1);
   endtask

   task automatic test_reset_midframe();
      logic [31:0] got[9];
      string       nm[9] = '{"mid_period", "mid_p1width", "mid_delay", "mid_p2width", "mid_npulses",
                             "mid_block", "mid_window", "mid_valid", "mid_timeout"};
      drive_frame(HAHN, 120, 1'b0);
      @(posedge clk_pll);
      #1 reset = 1'b0;
      #1;
      got = '{meas_period, meas_p1width, meas_delay, meas_p2width, {24'd0, meas_npulses},
              meas_block, meas_window, {31'd0, meas_valid}, {31'd0, timeout}};
      for (int k = 0; k < 9; k++) begin
         n_total++;
         if (got[k] !== 32'd0) $display("FAIL %s: got %0d required 0", nm[k], got[k]);
         else n_pass++;
      end
      sync_on = 1'b0; pulse_on = 1'b0; inhib = 1'b1;
      repeat (3) @(posedge clk_pll);
      #1 reset = 1'b1;
      repeat (5) step(1'b0, 1'b0, 1'b1);
      drive_frame(HAHN, HAHN.period, 1'b1);
      check_pending("reset_after", 1);
   endtask

   task automatic test_drain();
      drive_frame(HAHN, 20, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b1);
      check_pending("drain", 0);
   endtask

   initial begin
      test_reset();
      test_hahn();
      test_cpmg();
      test_pump_off();
      test_truncation();
      test_saturation();
      test_timeout();
      test_reset_midframe();
      test_drain();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
